// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and constants for the two-master memory arbiter
//
// Purpose: arbiter FSM state encoding, master identifiers and arbitration mode values.
// Ports  : none (package).

package vec_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_e;

   typedef enum logic {
      MST_CPU = 1'b0,
      MST_VEC = 1'b1
   } master_e;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// rtl/mem_arb_sat_cnt.sv - saturating event counter used for per-master grant statistics
//
// Purpose: counts increment requests and holds at the all-ones value.
// Ports  : clk    - rising-edge clock
//          rst    - asynchronous active-high reset, clears the count
//          inc_i  - add one this cycle (ignored once saturated)
//          cnt_o  - current count

module mem_arb_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/vec_mem_arbiter.sv
// rtl/vec_mem_arbiter.sv - CPU / vector coprocessor arbiter onto one shared memory port
//
// Purpose: serializes picorv32-style requests from the scalar CPU and the vector unit onto a
//          single registered slave port, traps out-of-range addresses and counts grants.
// Ports  : clk, rst                   - clock, asynchronous active-high reset
//          cpu_mem_*                  - CPU master port (valid/instr/addr/wdata/wstrb in, ready/rdata out)
//          vec_mem_*                  - vector master port (no instr bit)
//          mem_valid/instr/addr/wdata/wstrb - registered slave request
//          mem_ready, mem_rdata       - slave completion and read data
//          addr_err                   - sticky out-of-range flag
//          cpu_grants, vec_grants     - saturating grant counters

module vec_mem_arbiter
   import vec_mem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ARB_MODE  = ARB_RR,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_mem_valid,
   input  logic             cpu_mem_instr,
   input  logic [31:0]      cpu_mem_addr,
   input  logic [31:0]      cpu_mem_wdata,
   input  logic [3:0]       cpu_mem_wstrb,
   output logic             cpu_mem_ready,
   output logic [31:0]      cpu_mem_rdata,
   input  logic             vec_mem_valid,
   input  logic [31:0]      vec_mem_addr,
   input  logic [31:0]      vec_mem_wdata,
   input  logic [3:0]       vec_mem_wstrb,
   output logic             vec_mem_ready,
   output logic [31:0]      vec_mem_rdata,
   output logic             mem_valid,
   output logic             mem_instr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_ready,
   input  logic [31:0]      mem_rdata,
   output logic             addr_err,
   output logic [CNT_W-1:0] cpu_grants,
   output logic [CNT_W-1:0] vec_grants
);

   arb_state_e  state_q;
   master_e     last_grant_q;
   master_e     owner_q;
   logic        mem_valid_q;
   logic        mem_instr_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_wstrb_q;
   logic        cpu_ready_q;
   logic        vec_ready_q;
   logic [31:0] cpu_rdata_q;
   logic [31:0] vec_rdata_q;
   logic        addr_err_q;

   logic        req_any;
   logic        grant_cpu;
   logic        grant_vec;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;
   logic        sel_instr;
   logic        sel_in_range;

   // Valids are only looked at in IDLE; a master still holding valid during its
   // RESP cycle therefore cannot be granted a second time.
   always_comb begin
      req_any      = (state_q == ST_IDLE) && (cpu_mem_valid || vec_mem_valid);
      // CPU wins when alone, in fixed-priority mode, or when the vector unit had the last grant.
      grant_cpu    = req_any && cpu_mem_valid &&
                     (!vec_mem_valid || (ARB_MODE == ARB_FIXED) || (last_grant_q == MST_VEC));
      grant_vec    = req_any && !grant_cpu;
      sel_addr     = grant_cpu ? cpu_mem_addr  : vec_mem_addr;
      sel_wdata    = grant_cpu ? cpu_mem_wdata : vec_mem_wdata;
      sel_wstrb    = grant_cpu ? cpu_mem_wstrb : vec_mem_wstrb;
      sel_instr    = grant_cpu && cpu_mem_instr;
      sel_in_range = sel_addr < 32'(MEM_BYTES);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= MST_VEC;
         owner_q      <= MST_CPU;
         mem_valid_q  <= 1'b0;
         mem_instr_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         cpu_ready_q  <= 1'b0;
         vec_ready_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         vec_rdata_q  <= '0;
         addr_err_q   <= 1'b0;
      end else begin
         // Readies are single-cycle pulses: only the transition into RESP sets one.
         cpu_ready_q <= 1'b0;
         vec_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_any) begin
                  owner_q      <= grant_cpu ? MST_CPU : MST_VEC;
                  last_grant_q <= grant_cpu ? MST_CPU : MST_VEC;
                  if (sel_in_range) begin
                     mem_valid_q <= 1'b1;
                     mem_instr_q <= sel_instr;
                     mem_addr_q  <= sel_addr;
                     mem_wdata_q <= sel_wdata;
                     mem_wstrb_q <= sel_wstrb;
                     state_q     <= ST_ISSUE;
                  end else begin
                     // Trapped locally: the slave port is left untouched and the
                     // requester is completed with zero data.
                     addr_err_q <= 1'b1;
                     if (grant_cpu) begin
                        cpu_ready_q <= 1'b1;
                        cpu_rdata_q <= '0;
                     end else begin
                        vec_ready_q <= 1'b1;
                        vec_rdata_q <= '0;
                     end
                     state_q <= ST_RESP;
                  end
               end
            end
            ST_ISSUE: begin
               if (mem_ready) begin
                  mem_valid_q <= 1'b0;
                  if (owner_q == MST_CPU) begin
                     cpu_ready_q <= 1'b1;
                     cpu_rdata_q <= mem_rdata;
                  end else begin
                     vec_ready_q <= 1'b1;
                     vec_rdata_q <= mem_rdata;
                  end
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q     <= ST_IDLE;
               mem_valid_q <= 1'b0;
            end
         endcase
      end
   end

   mem_arb_sat_cnt #(.W(CNT_W)) u_cpu_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (grant_cpu),
      .cnt_o (cpu_grants)
   );

   mem_arb_sat_cnt #(.W(CNT_W)) u_vec_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (grant_vec),
      .cnt_o (vec_grants)
   );

   assign mem_valid     = mem_valid_q;
   assign mem_instr     = mem_instr_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wstrb     = mem_wstrb_q;
   assign cpu_mem_ready = cpu_ready_q;
   assign cpu_mem_rdata = cpu_rdata_q;
   assign vec_mem_ready = vec_ready_q;
   assign vec_mem_rdata = vec_rdata_q;
   assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// tb/tb_vec_mem_arbiter.sv - directed self-checking bench for vec_mem_arbiter

module tb_vec_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic stall;
   int   checks   = 0;
   int   failures = 0;

   // Shared master data lines; valids are per instance.
   logic        cpu_instr;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_wstrb;
   logic [31:0] vec_addr;
   logic [31:0] vec_wdata;
   logic [3:0]  vec_wstrb;
   logic        cpu_valid_a, vec_valid_a, cpu_valid_b, vec_valid_b;

   // Instance a: round-robin, 16-bit counters.
   logic        cpu_ready_a, vec_ready_a, mem_valid_a, mem_instr_a, mem_ready_a, addr_err_a;
   logic [31:0] cpu_rdata_a, vec_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic [3:0]  mem_wstrb_a;
   logic [15:0] cpu_grants_a, vec_grants_a;

   // Instance b: fixed priority, 2-bit counters.
   logic        cpu_ready_b, vec_ready_b, mem_valid_b, mem_instr_b, mem_ready_b, addr_err_b;
   logic [31:0] cpu_rdata_b, vec_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic [3:0]  mem_wstrb_b;
   logic [1:0]  cpu_grants_b, vec_grants_b;

   logic [31:0] mem_model [0:255];
   bit          log_a [$];
   bit          log_b [$];
   int          valid_cycles_a = 0;
   int          slave_writes_a = 0;

   vec_mem_arbiter #(.MEM_BYTES(1024), .ARB_MODE(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst),
      .cpu_mem_valid(cpu_valid_a), .cpu_mem_instr(cpu_instr), .cpu_mem_addr(cpu_addr),
      .cpu_mem_wdata(cpu_wdata), .cpu_mem_wstrb(cpu_wstrb),
      .cpu_mem_ready(cpu_ready_a), .cpu_mem_rdata(cpu_rdata_a),
      .vec_mem_valid(vec_valid_a), .vec_mem_addr(vec_addr), .vec_mem_wdata(vec_wdata),
      .vec_mem_wstrb(vec_wstrb), .vec_mem_ready(vec_ready_a), .vec_mem_rdata(vec_rdata_a),
      .mem_valid(mem_valid_a), .mem_instr(mem_instr_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a), .mem_ready(mem_ready_a),
      .mem_rdata(mem_rdata_a), .addr_err(addr_err_a),
      .cpu_grants(cpu_grants_a), .vec_grants(vec_grants_a)
   );

   vec_mem_arbiter #(.MEM_BYTES(1024), .ARB_MODE(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst),
      .cpu_mem_valid(cpu_valid_b), .cpu_mem_instr(cpu_instr), .cpu_mem_addr(cpu_addr),
      .cpu_mem_wdata(cpu_wdata), .cpu_mem_wstrb(cpu_wstrb),
      .cpu_mem_ready(cpu_ready_b), .cpu_mem_rdata(cpu_rdata_b),
      .vec_mem_valid(vec_valid_b), .vec_mem_addr(vec_addr), .vec_mem_wdata(vec_wdata),
      .vec_mem_wstrb(vec_wstrb), .vec_mem_ready(vec_ready_b), .vec_mem_rdata(vec_rdata_b),
      .mem_valid(mem_valid_b), .mem_instr(mem_instr_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b), .mem_ready(mem_ready_b),
      .mem_rdata(mem_rdata_b), .addr_err(addr_err_b),
      .cpu_grants(cpu_grants_b), .vec_grants(vec_grants_b)
   );

   // Single-cycle slaves: answer in the first ISSUE cycle unless stalled.
   assign mem_ready_a = mem_valid_a & ~stall;
   assign mem_rdata_a = mem_model[mem_addr_a[9:2]];
   assign mem_ready_b = mem_valid_b & ~stall;
   assign mem_rdata_b = mem_model[mem_addr_b[9:2]];

   always @(posedge clk) begin
      if (mem_valid_a) valid_cycles_a <= valid_cycles_a + 1;
      if (mem_valid_a && mem_ready_a) begin
         log_a.push_back(mem_instr_a);
         if (mem_wstrb_a != 4'h0) slave_writes_a <= slave_writes_a + 1;
      end
      if (mem_valid_b && mem_ready_b) log_b.push_back(mem_instr_b);
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Called #1 after a rising edge; returns number of edges until ready (-1 on timeout).
   task automatic cpu_xfer(input bit sel, input logic [31:0] addr, input logic instr,
                           output logic [31:0] rdata, output int waited);
      cpu_addr  = addr;
      cpu_instr = instr;
      if (sel) cpu_valid_b = 1'b1; else cpu_valid_a = 1'b1;
      waited = -1;
      rdata  = 32'hxxxx_xxxx;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if ((sel ? cpu_ready_b : cpu_ready_a) === 1'b1) begin
            rdata  = sel ? cpu_rdata_b : cpu_rdata_a;
            waited = i;
            break;
         end
      end
      @(posedge clk); #1;
      if (sel) cpu_valid_b = 1'b0; else cpu_valid_a = 1'b0;
   endtask

   task automatic vec_xfer(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] rdata, output int waited);
      vec_addr  = addr;
      vec_wdata = wdata;
      vec_wstrb = wstrb;
      if (sel) vec_valid_b = 1'b1; else vec_valid_a = 1'b1;
      waited = -1;
      rdata  = 32'hxxxx_xxxx;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if ((sel ? vec_ready_b : vec_ready_a) === 1'b1) begin
            rdata  = sel ? vec_rdata_b : vec_rdata_a;
            waited = i;
            break;
         end
      end
      @(posedge clk); #1;
      if (sel) vec_valid_b = 1'b0; else vec_valid_a = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (mem_valid_a !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid_a); end
      checks++; if ({cpu_ready_a, vec_ready_a} !== 2'b00) begin failures++; $display("FAIL reset_readys got=%b exp=00", {cpu_ready_a, vec_ready_a}); end
      checks++; if ({cpu_rdata_a, vec_rdata_a} !== 64'h0) begin failures++; $display("FAIL reset_rdatas got=%h exp=0", {cpu_rdata_a, vec_rdata_a}); end
      checks++; if ({mem_addr_a, mem_wdata_a, mem_wstrb_a, mem_instr_a} !== 69'h0) begin failures++; $display("FAIL reset_mem_fields got=%h exp=0", {mem_addr_a, mem_wdata_a, mem_wstrb_a, mem_instr_a}); end
      checks++; if ({addr_err_a, cpu_grants_a, vec_grants_a} !== 33'h0) begin failures++; $display("FAIL reset_err_counters got=%h exp=0", {addr_err_a, cpu_grants_a, vec_grants_a}); end
      checks++; if ({mem_valid_b, cpu_grants_b, vec_grants_b} !== 5'h0) begin failures++; $display("FAIL reset_b got=%h exp=0", {mem_valid_b, cpu_grants_b, vec_grants_b}); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_cpu_read();
      logic [31:0] r;
      int          w;
      // Valid in cycle 1, ISSUE in cycle 2, ready in cycle 3: two edges after valid rises.
      cpu_xfer(1'b0, 32'd400, 1'b0, r, w);
      checks++; if (w !== 2) begin failures++; $display("FAIL cpu_read_latency got=%0d exp=2", w); end
      checks++; if (r !== 32'h0000_0201) begin failures++; $display("FAIL cpu_read_rdata got=%h exp=00000201", r); end
      checks++; if (cpu_ready_a !== 1'b0) begin failures++; $display("FAIL cpu_ready_pulse_width got=%b exp=0", cpu_ready_a); end
      checks++; if (cpu_grants_a !== 16'd1) begin failures++; $display("FAIL cpu_read_grants got=%0d exp=1", cpu_grants_a); end
   endtask

   task automatic test_vec_burst();
      logic [31:0] r;
      int          w;
      int          base;
      base = log_a.size();
      for (int k = 0; k < 8; k++) begin
         vec_xfer(1'b0, 32'd400 + 32'(4 * k), 32'h0, 4'h0, r, w);
         checks++; if (r !== 32'h0000_0201 + 32'(k)) begin failures++; $display("FAIL vec_burst_rdata[%0d] got=%h exp=%h", k, r, 32'h0000_0201 + 32'(k)); end
      end
      checks++; if (vec_grants_a !== 16'd8) begin failures++; $display("FAIL vec_burst_grants got=%0d exp=8", vec_grants_a); end
      checks++; if (log_a.size() - base !== 8) begin failures++; $display("FAIL vec_burst_slave_count got=%0d exp=8", log_a.size() - base); end
      for (int k = base; k < log_a.size(); k++) begin
         checks++; if (log_a[k] !== 1'b0) begin failures++; $display("FAIL vec_burst_mem_instr[%0d] got=%b exp=0", k - base, log_a[k]); end
      end
   endtask

   task automatic test_round_robin();
      bit exp_order [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int base;
      base = log_a.size();
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               logic [31:0] r;
               int          w;
               cpu_xfer(1'b0, 32'(4 * k), 1'b1, r, w);
               checks++; if (r !== 32'h0000_019D + 32'(k)) begin failures++; $display("FAIL rr_cpu_rdata[%0d] got=%h exp=%h", k, r, 32'h0000_019D + 32'(k)); end
            end
         end
         begin
            for (int k = 0; k < 4; k++) begin
               logic [31:0] r;
               int          w;
               vec_xfer(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'h0, r, w);
               checks++; if (r !== 32'h0000_021D + 32'(k)) begin failures++; $display("FAIL rr_vec_rdata[%0d] got=%h exp=%h", k, r, 32'h0000_021D + 32'(k)); end
            end
         end
      join
      checks++; if (log_a.size() - base !== 8) begin failures++; $display("FAIL rr_slave_count got=%0d exp=8", log_a.size() - base); end
      for (int k = 0; k < 8 && base + k < log_a.size(); k++) begin
         checks++; if (log_a[base + k] !== exp_order[k]) begin failures++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, log_a[base + k], exp_order[k]); end
      end
      checks++; if (cpu_grants_a !== 16'd5) begin failures++; $display("FAIL rr_cpu_grants got=%0d exp=5", cpu_grants_a); end
      checks++; if (vec_grants_a !== 16'd12) begin failures++; $display("FAIL rr_vec_grants got=%0d exp=12", vec_grants_a); end
   endtask

   task automatic test_fixed_priority_saturation();
      bit          exp_order [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] r;
      int          w;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               logic [31:0] rc;
               int          wc;
               cpu_xfer(1'b1, 32'(4 * k), 1'b1, rc, wc);
            end
         end
         begin
            for (int k = 0; k < 4; k++) begin
               logic [31:0] rv;
               int          wv;
               vec_xfer(1'b1, 32'h200 + 32'(4 * k), 32'h0, 4'h0, rv, wv);
            end
         end
      join
      checks++; if (log_b.size() !== 8) begin failures++; $display("FAIL fp_slave_count got=%0d exp=8", log_b.size()); end
      for (int k = 0; k < 8 && k < log_b.size(); k++) begin
         checks++; if (log_b[k] !== exp_order[k]) begin failures++; $display("FAIL fp_order[%0d] got=%b exp=%b", k, log_b[k], exp_order[k]); end
      end
      checks++; if (vec_grants_b !== 2'd3) begin failures++; $display("FAIL fp_vec_grants_sat got=%0d exp=3", vec_grants_b); end
      // Fifth CPU grant: the 2-bit counter stays at 3.
      cpu_xfer(1'b1, 32'd16, 1'b1, r, w);
      checks++; if (r !== 32'h0000_01A1) begin failures++; $display("FAIL fp_cpu5_rdata got=%h exp=000001a1", r); end
      checks++; if (cpu_grants_b !== 2'd3) begin failures++; $display("FAIL sat_cpu_grants got=%0d exp=3", cpu_grants_b); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] r;
      int          w;
      int          vc0;
      int          wr0;
      checks++; if (addr_err_a !== 1'b0) begin failures++; $display("FAIL oor_err_before got=%b exp=0", addr_err_a); end
      vc0 = valid_cycles_a;
      wr0 = slave_writes_a;
      vec_xfer(1'b0, 32'd1024, 32'hDEAD_BEEF, 4'hF, r, w);
      checks++; if (w !== 1) begin failures++; $display("FAIL oor_latency got=%0d exp=1", w); end
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL oor_rdata got=%h exp=00000000", r); end
      checks++; if (valid_cycles_a !== vc0) begin failures++; $display("FAIL oor_mem_valid_cycles got=%0d exp=%0d", valid_cycles_a, vc0); end
      checks++; if (slave_writes_a !== wr0) begin failures++; $display("FAIL oor_slave_writes got=%0d exp=%0d", slave_writes_a, wr0); end
      checks++; if (addr_err_a !== 1'b1) begin failures++; $display("FAIL oor_err_set got=%b exp=1", addr_err_a); end
      checks++; if (cpu_rdata_a !== 32'h0000_01A0) begin failures++; $display("FAIL oor_cpu_rdata_hold got=%h exp=000001a0", cpu_rdata_a); end
      cpu_xfer(1'b0, 32'd0, 1'b0, r, w);
      checks++; if (r !== 32'h0000_019D) begin failures++; $display("FAIL oor_followup_rdata got=%h exp=0000019d", r); end
      checks++; if (addr_err_a !== 1'b1) begin failures++; $display("FAIL oor_err_sticky got=%b exp=1", addr_err_a); end
   endtask

   task automatic test_reset_mid_issue();
      logic [31:0] r;
      int          w;
      bit          got_valid;
      bit          saw_ready;
      stall       = 1'b1;
      cpu_addr    = 32'd400;
      cpu_instr   = 1'b0;
      cpu_valid_a = 1'b1;
      got_valid   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (mem_valid_a === 1'b1) begin
            got_valid = 1'b1;
            break;
         end
      end
      checks++; if (got_valid !== 1'b1) begin failures++; $display("FAIL rst_issue_reached got=%b exp=1", got_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (mem_valid_a !== 1'b0) begin failures++; $display("FAIL rst_async_mem_valid got=%b exp=0", mem_valid_a); end
      cpu_valid_a = 1'b0;
      stall       = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      saw_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (cpu_ready_a !== 1'b0) saw_ready = 1'b1;
      end
      checks++; if (saw_ready !== 1'b0) begin failures++; $display("FAIL rst_no_ready got=%b exp=0", saw_ready); end
      checks++; if ({addr_err_a, cpu_grants_a, vec_grants_a} !== 33'h0) begin failures++; $display("FAIL rst_clears_state got=%h exp=0", {addr_err_a, cpu_grants_a, vec_grants_a}); end
      cpu_xfer(1'b0, 32'd400, 1'b0, r, w);
      checks++; if (r !== 32'h0000_0201 || w !== 2) begin failures++; $display("FAIL rst_next_request got=%h/%0d exp=00000201/2", r, w); end
      checks++; if (cpu_grants_a !== 16'd1) begin failures++; $display("FAIL rst_next_grants got=%0d exp=1", cpu_grants_a); end
   endtask

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      cpu_valid_a = 1'b0;
      vec_valid_a = 1'b0;
      cpu_valid_b = 1'b0;
      vec_valid_b = 1'b0;
      cpu_instr   = 1'b0;
      cpu_addr    = 32'h0;
      cpu_wdata   = 32'h0;
      cpu_wstrb   = 4'h0;
      vec_addr    = 32'h0;
      vec_wdata   = 32'h0;
      vec_wstrb   = 4'h0;
      // memory[i] = 0x19D + i, so memory[100] = 0x201.
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0000_019D + 32'(i);
      #1;
      test_reset();
      test_cpu_read();
      test_vec_burst();
      test_round_robin();
      test_fixed_priority_saturation();
      test_out_of_range();
      test_reset_mid_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
